reg_bank_param: RTL

- Parametrised next-generation register bank for the C0 datapath: DEPTH registers of WIDTH bits, one write port, two independent read ports.
- Write data comes from a 4-way source mux (ALU / REG / IMM / MEM). The MEM leg is a live input, not tied low.
- Adds in-place register ops (load, increment, decrement, clear) with a registered carry/borrow flag.
- Optional read-after-write bypass and optional hardwired-zero R0.

---
 rtl/reg_bank_param.sv | 138 +++++++++++++
 1 files changed

// File: rtl/reg_bank_param.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_param
// Purpose  : DEPTH x WIDTH register bank with one write port, two read ports,
//            in-place inc/dec/clear ops, carry flag, optional bypass and R0.
// Revision : 1.0  initial release
// ============================================================================
module reg_bank_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [AW-1:0]    WSEL,
    input  logic [1:0]       OP,
    input  logic [1:0]       MS,
    input  logic [WIDTH-1:0] ALU,
    input  logic [WIDTH-1:0] REG,
    input  logic [WIDTH-1:0] IMM,
    input  logic [WIDTH-1:0] MEM,
    input  logic [AW-1:0]    RSA,
    input  logic [AW-1:0]    RSB,
    output logic [WIDTH-1:0] RA,
    output logic [WIDTH-1:0] RB,
    output logic             CY,
    output logic             WR_ACK
);

    localparam logic [1:0]   c_OP_LOAD = 2'b00;
    localparam logic [1:0]   c_OP_INC  = 2'b01;
    localparam logic [1:0]   c_OP_DEC  = 2'b10;
    localparam logic [1:0]   c_OP_CLR  = 2'b11;
    localparam logic [1:0]   c_MS_ALU  = 2'b00;
    localparam logic [1:0]   c_MS_REG  = 2'b01;
    localparam logic [1:0]   c_MS_IMM  = 2'b10;
    localparam logic [WIDTH:0] c_ONE   = (WIDTH+1)'(1);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             r_cy;
    logic             r_ack;

    logic             w_zero_dst;
    logic             w_byp_en;
    logic [WIDTH-1:0] w_old;
    logic [WIDTH-1:0] w_mux;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic [WIDTH-1:0] w_result;
    logic             w_cy_next;

    // A hardwired R0 behaves as if it always held zero, so ops on it see old=0.
    assign w_zero_dst = (ZERO_REG != 0) && (WSEL == '0);
    assign w_old      = w_zero_dst ? '0 : r_regs[WSEL];
    assign w_inc      = {1'b0, w_old} + c_ONE;
    assign w_dec      = {1'b0, w_old} - c_ONE;
    assign w_byp_en   = (BYPASS != 0) && WE && !RST;

    always_comb begin
        w_mux = MEM;
        case (MS)
            c_MS_ALU: w_mux = ALU;
            c_MS_REG: w_mux = REG;
            c_MS_IMM: w_mux = IMM;
            default:  w_mux = MEM;
        endcase
    end

    always_comb begin
        w_result  = w_mux;
        w_cy_next = r_cy;
        case (OP)
            c_OP_LOAD: begin
                w_result  = w_mux;
                w_cy_next = r_cy;
            end
            c_OP_INC: begin
                w_result  = w_inc[WIDTH-1:0];
                w_cy_next = w_inc[WIDTH];
            end
            c_OP_DEC: begin
                w_result  = w_dec[WIDTH-1:0];
                w_cy_next = w_dec[WIDTH];
            end
            c_OP_CLR: begin
                w_result  = '0;
                w_cy_next = 1'b0;
            end
            default: begin
                w_result  = w_mux;
                w_cy_next = r_cy;
            end
        endcase
    end

    always_comb begin
        if ((ZERO_REG != 0) && (RSA == '0))
            RA = '0;
        else if (w_byp_en && (RSA == WSEL))
            RA = w_result;
        else
            RA = r_regs[RSA];
    end

    always_comb begin
        if ((ZERO_REG != 0) && (RSB == '0))
            RB = '0;
        else if (w_byp_en && (RSB == WSEL))
            RB = w_result;
        else
            RB = r_regs[RSB];
    end

    // State updates on the falling edge to line up with the existing cells.
    always_ff @(negedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
            r_cy  <= 1'b0;
            r_ack <= 1'b0;
        end else begin
            r_ack <= WE;
            if (WE) begin
                if (!w_zero_dst)
                    r_regs[WSEL] <= w_result;
                r_cy <= w_cy_next;
            end
        end
    end

    assign CY     = r_cy;
    assign WR_ACK = r_ack;

endmodule
`default_nettype wire
